pipe_skid_buffer: RTL and testbench
===================================

# pipe_skid_buffer

Two-entry elastic pipeline register with a valid/ready handshake on both sides, placed between processor pipeline stages in place of a plain enable register. It accepts one word per cycle from the upstream writer and holds it until the downstream reader takes it. A skid entry absorbs one extra word when the reader stalls, so both sides run at full throughput without a combinational ready path. A synchronous flush empties the buffer on a pipeline redirect.

## Interface
- Width, 32, data word width in bits
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous clear; discards all held words
- In_Valid  in  1  upstream word present
- In_Data  in  Width  upstream word
- In_Ready  out  1  buffer can accept a word this cycle
- Out_Valid  out  1  Out_Data holds a valid word
- Out_Data  out  Width  head word
- Out_Ready  in  1  downstream takes the head word this cycle
- Count  out  2  number of held words (0..2)

## Operation
- Input fire (IF) = In_Valid & In_Ready. Output fire (OF) = Out_Valid & Out_Ready.
- Storage: main register (drives Out_Data) and skid register.
- States:
  - EMPTY (Count 0)
  - BUSY (Count 1, main valid)
  - FULL (Count 2, main and skid valid)
- EMPTY:
  - IF → BUSY, main <= In_Data.
  - Otherwise stay.
- BUSY:
  - IF & OF → BUSY, main <= In_Data.
  - IF & !OF → FULL, skid <= In_Data.
  - !IF & OF → EMPTY.
  - Neither → hold.
- FULL:
  - OF → BUSY, main <= skid.
  - Otherwise hold. In_Ready = 0, so IF cannot occur.
- Outputs decode from registered state:
  - Out_Valid = (state != EMPTY).
  - In_Ready = (state != FULL) & Reset.
  - No combinational path from Out_Ready to In_Ready.
- Flush has priority over all transitions:
  - Next state EMPTY.
  - Any IF or OF in the same cycle is discarded: the word is not stored and is not counted as delivered.
  - Data registers need not be cleared.
- Ordering: words leave in the order they arrive. No duplication, no loss except on Flush or Reset.
- Out_Data is held stable while Out_Valid & !Out_Ready.
- Words pass through unmodified at the full Width. There is no arithmetic on data.

## Timing
- Reset asserted (low), asynchronously:
  - state EMPTY, Out_Valid 0, Out_Data 0, Count 0.
  - In_Ready 0 while Reset is low, 1 in the first cycle after release.
- Reset asserted mid-operation: all held words are lost immediately; no partial output.
- Latency: a word accepted at edge N is visible on Out_Data/Out_Valid after edge N (one cycle).
- Throughput: one word per cycle sustained when Out_Ready stays high.
- Stall: Out_Ready low with In_Valid high fills BUSY → FULL in one cycle. In_Ready drops the cycle after the skid loads.
- Stall release from FULL:
  - Cycle 1: OF moves skid to main; In_Ready returns high.
  - Cycle 2 onward: upstream resumes at one word per cycle.
- Simultaneous IF & OF in BUSY keeps Count at 1.
- Flush with Reset high takes effect at the next edge: Out_Valid 0 and In_Ready 1 after that edge.

## Structure
- Shared pipeline package holds:
  - state typedef (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10)
  - default Width constant
- One sub-module, pipe_skid_ctrl:
  - Contains the state machine and the load enables (main from input, main from skid, skid from input).
  - Outputs In_Ready, Out_Valid and Count.
- Top-level pipe_skid_buffer holds the two Width-bit data registers.

## Test plan
- Stream: Out_Ready=1, In_Valid=1 with data 0x1..0x8 on consecutive cycles → Out_Data 0x1..0x8 each one cycle later, Count stays 1, In_Ready never drops.
- Backpressure: stream 0xA0, 0xA1, 0xA2 with Out_Ready=0 → Count 1 then 2; In_Ready 0 after 0xA1 lands; 0xA2 held upstream. Raise Out_Ready → output order 0xA0, 0xA1, 0xA2 with none lost.
- Simultaneous: in BUSY holding 0x55, IF=0x66 and OF in the same cycle → next cycle Out_Data 0x66, Count 1.
- Flush: FULL holding 0x11/0x22, Flush=1 with In_Valid=1 (0x33) → next cycle Out_Valid 0, Count 0, 0x33 not delivered.
- Reset mid-operation: FULL state, assert Reset low between clock edges → Out_Valid, Out_Data, Count go to 0 immediately and In_Ready is 0. After release, In_Ready=1 and the first new word 0x77 appears one cycle after acceptance.
- Random: random In_Valid/Out_Ready, 10k cycles, scoreboard check → in-order, lossless delivery; Out_Data stable whenever Out_Valid & !Out_Ready.

Source files
------------

// File: rtl/pipe_skid_pkg.sv
// ----------------------------------------------------------------------------
// pipe_skid_pkg : shared types and constants for the two-entry skid buffer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_skid_pkg;

   localparam int unsigned WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b10
   } state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_skid_ctrl : occupancy state machine and data-register load enables
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_skid_ctrl
   import pipe_skid_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   input  logic       in_valid_i,
   input  logic       out_ready_i,
   output logic       in_ready_o,
   output logic       out_valid_o,
   output logic [1:0] count_o,
   output logic       ld_main_in_o,
   output logic       ld_main_skid_o,
   output logic       ld_skid_in_o
);

   state_e state_q;
   state_e state_d;
   logic   w_in_fire;
   logic   w_out_fire;

   // Ready decodes from registered state only, never from out_ready_i.
   assign in_ready_o  = (state_q != ST_FULL) & rst_ni;
   assign out_valid_o = (state_q != ST_EMPTY);
   assign w_in_fire   = in_valid_i & in_ready_o;
   assign w_out_fire  = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (w_in_fire) state_d = ST_BUSY;
            ST_BUSY: begin
               if (w_in_fire && !w_out_fire)      state_d = ST_FULL;
               else if (!w_in_fire && w_out_fire) state_d = ST_EMPTY;
            end
            ST_FULL:  if (w_out_fire) state_d = ST_BUSY;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      ld_main_in_o   = 1'b0;
      ld_main_skid_o = 1'b0;
      ld_skid_in_o   = 1'b0;
      count_o        = 2'd0;
      case (state_q)
         ST_BUSY: count_o = 2'd1;
         ST_FULL: count_o = 2'd2;
         default: count_o = 2'd0;
      endcase
      if (!flush_i) begin
         ld_main_in_o   = w_in_fire & ((state_q == ST_EMPTY) |
                                       ((state_q == ST_BUSY) & w_out_fire));
         ld_skid_in_o   = w_in_fire & (state_q == ST_BUSY) & ~w_out_fire;
         ld_main_skid_o = w_out_fire & (state_q == ST_FULL);
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_skid_buffer.sv
// ----------------------------------------------------------------------------
// pipe_skid_buffer : two-entry elastic pipeline register with flush
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_skid_buffer
   import pipe_skid_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   input  logic             out_ready_i,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_d;
   logic             w_ld_main_in;
   logic             w_ld_main_skid;
   logic             w_ld_skid_in;

   pipe_skid_ctrl u_ctrl (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .in_valid_i     (in_valid_i),
      .out_ready_i    (out_ready_i),
      .in_ready_o     (in_ready_o),
      .out_valid_o    (out_valid_o),
      .count_o        (count_o),
      .ld_main_in_o   (w_ld_main_in),
      .ld_main_skid_o (w_ld_main_skid),
      .ld_skid_in_o   (w_ld_skid_in)
   );

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (w_ld_main_in)        main_d = in_data_i;
      else if (w_ld_main_skid) main_d = skid_q;
      if (w_ld_skid_in)        skid_d = in_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   assign out_data_o = main_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
// ----------------------------------------------------------------------------
// tb_pipe_skid_buffer : directed vector table, reset corner case, random run
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_skid_buffer;

   typedef struct {
      logic        flush;
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      logic [1:0]  e_cnt;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   vec_t        vecs[$];
   logic [31:0] sb[$];

   pipe_skid_buffer #(.WIDTH(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_ready_i (out_ready),
      .count_o     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic ir, input logic ov,
                              input logic [31:0] od, input logic [1:0] cnt);
      chk({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, ir});
      chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
      chk({tag, " count"},     {30'd0, count},     {30'd0, cnt});
      if (ov) chk({tag, " out_data"}, out_data, od);
   endtask

   task automatic drive(input logic f, input logic iv, input logic [31:0] id, input logic ordy);
      flush     = f;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);

      // stream 1..8 at full rate
      for (int k = 1; k <= 8; k++)
         vecs.push_back('{1'b0, 1'b1, 32'(k), 1'b1, 1'b1, 1'b1, 32'(k), 2'd1});
      vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});
      // backpressure then release
      vecs.push_back('{1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 32'hA0, 2'd1});
      vecs.push_back('{1'b0, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd2});
      vecs.push_back('{1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd2});
      vecs.push_back('{1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA1, 2'd1});
      vecs.push_back('{1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA2, 2'd1});
      vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});
      // simultaneous in and out while busy
      vecs.push_back('{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h55, 2'd1});
      vecs.push_back('{1'b0, 1'b1, 32'h66, 1'b1, 1'b1, 1'b1, 32'h66, 2'd1});
      vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});
      // flush from full with a concurrent input word
      vecs.push_back('{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 2'd1});
      vecs.push_back('{1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2});
      vecs.push_back('{1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0});
      vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});
      // flush from busy with concurrent in and out fire
      vecs.push_back('{1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 32'h44, 2'd1});
      vecs.push_back('{1'b1, 1'b1, 32'h45, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0});
      vecs.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  2'd0});

      #1;
      chk_outputs("reset", 1'b0, 1'b0, 32'h0, 2'd0);
      chk("reset out_data", out_data, 32'h0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
      chk_outputs("release", 1'b1, 1'b0, 32'h0, 2'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         @(posedge clk); #2;
         chk_outputs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_cnt);
      end

      // asynchronous reset while full
      drive(1'b0, 1'b1, 32'h11, 1'b0);
      @(posedge clk); #2;
      drive(1'b0, 1'b1, 32'h22, 1'b0);
      @(posedge clk); #2;
      chk_outputs("prefill", 1'b0, 1'b1, 32'h11, 2'd2);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk_outputs("midrst", 1'b0, 1'b0, 32'h0, 2'd0);
      chk("midrst out_data", out_data, 32'h0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
      chk_outputs("midrst release", 1'b1, 1'b0, 32'h0, 2'd0);
      drive(1'b0, 1'b1, 32'h77, 1'b0);
      @(posedge clk); #2;
      chk_outputs("first 77", 1'b1, 1'b1, 32'h77, 2'd1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      @(posedge clk); #2;
      chk_outputs("drain 77", 1'b1, 1'b0, 32'h0, 2'd0);

      // random traffic against a queue scoreboard
      begin
         logic        prev_stall;
         logic [31:0] prev_data;
         logic        in_fire;
         logic        out_fire;
         prev_stall = 1'b0;
         prev_data  = '0;
         sb.delete();
         for (int c = 0; c < 10000; c++) begin
            chk("rnd count", {30'd0, count}, 32'(sb.size()));
            chk("rnd out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            if (out_valid && sb.size() != 0) chk("rnd order", out_data, sb[0]);
            if (prev_stall) chk("rnd hold", out_data, prev_data);
            drive(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
            if (($urandom_range(0, 7) == 0)) out_ready = 1'b0;
            #1;
            in_fire  = in_valid & in_ready;
            out_fire = out_valid & out_ready;
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            if (out_fire && sb.size() != 0) void'(sb.pop_front());
            if (in_fire) sb.push_back(in_data);
            @(posedge clk); #2;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
